keypad_scan: RTL

- 4x4 matrix keypad scanner; input-side counterpart to the digit-scan display path.
- Drives one active-low row at a time, samples the four active-low column lines, debounces, and emits a 4-bit key code with a one-cycle valid strobe.
- Sits between the board keypad pins and the clock-setting control logic, in the same clk domain as the display scanner.

---
 rtl/keypad_scan_pkg.sv | 38 +++
 rtl/scan_tick_gen.sv | 22 ++
 rtl/keypad_scan.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its tick generator.
// The optional auto-repeat feature is enabled by defining KEYPAD_REPEAT_EN.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam logic [3:0] COL_NONE = 4'b1111;

  // Board legend: right-hand column carries the clock-setting controls.
  localparam logic [3:0] KEY_SET  = 4'd3;
  localparam logic [3:0] KEY_UP   = 4'd7;
  localparam logic [3:0] KEY_DOWN = 4'd11;
  localparam logic [3:0] KEY_MODE = 4'd15;

  // Lowest-numbered active-low column; caller guarantees at least one is low.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0]) return 2'd0;
    if (!c[1]) return 2'd1;
    if (!c[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return ROW_IDLE;
      2'd1:    return {ROW_IDLE[2:0], ROW_IDLE[3]};
      2'd2:    return {ROW_IDLE[1:0], ROW_IDLE[3:2]};
      default: return {ROW_IDLE[0], ROW_IDLE[3:1]};
    endcase
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV enabled clocks.
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic cr,
  input  logic en,
  output logic tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk or negedge cr)
    if (!cr)     div_cnt <= '0;
    else if (en) div_cnt <= tick ? '0 : div_cnt + DW'(1);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounce, key code + strobe.
// Define KEYPAD_REPEAT_EN to add hold-to-repeat strobes.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 200,
  parameter int REPEAT_RATE    = 50
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    col_s1, col_s2;
  logic          tick;
  kp_state_t     state, state_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [1:0]    cap_c, cap_c_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    code_n;
  logic          held_n, kv_q, kv_n;
  logic          col_hit, confirm, rel_done;

  always_ff @(posedge clk or negedge cr)
    if (!cr) begin
      col_s1 <= COL_NONE;
      col_s2 <= COL_NONE;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .cr   (cr),
    .en   (en),
    .tick (tick)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_n, rpt_inc;
  logic          rpt_armed, rpt_armed_n;

  always_ff @(posedge clk or negedge cr)
    if (!cr) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_n;
      rpt_armed <= rpt_armed_n;
    end
`endif

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    cap_c_n   = cap_c;
    cnt_n     = cnt;
    code_n    = key_code;
    held_n    = key_held;
    kv_n      = 1'b0;
    confirm   = 1'b0;
    rel_done  = 1'b0;
    cnt_inc   = cnt + CW'(1);
    col_hit   = !col_s2[cap_c];
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_n   = rpt_cnt;
    rpt_armed_n = rpt_armed;
    rpt_inc     = rpt_cnt + RW'(1);
`endif
    if (tick) begin
      unique case (state)
        SCAN:
          if (col_s2 != COL_NONE) begin
            cap_c_n = low_col(col_s2);
            cnt_n   = CW'(1);
            if (DEBOUNCE_SCANS == 1) confirm = 1'b1;
            else                     state_n = DEBOUNCE;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        DEBOUNCE:
          if (col_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) confirm = 1'b1;
          end else begin
            state_n   = SCAN;
            row_idx_n = row_idx + 2'd1;
          end
        PRESSED:
          if (!col_hit) begin
            cnt_n = CW'(1);
            if (DEBOUNCE_SCANS == 1) rel_done = 1'b1;
            else                     state_n  = RELEASE;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE.
            if (rpt_inc == (rpt_armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
              kv_n        = 1'b1;
              rpt_cnt_n   = '0;
              rpt_armed_n = 1'b1;
            end else begin
              rpt_cnt_n = rpt_inc;
            end
`endif
          end
        RELEASE:
          if (!col_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) rel_done = 1'b1;
          end else begin
            state_n = PRESSED;
          end
      endcase
    end
    if (confirm) begin
      state_n = PRESSED;
      code_n  = {row_idx, cap_c_n};
      held_n  = 1'b1;
      kv_n    = 1'b1;
    end
    if (rel_done) begin
      state_n   = SCAN;
      held_n    = 1'b0;
      row_idx_n = row_idx + 2'd1;
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_n != PRESSED || confirm) begin
      rpt_cnt_n   = '0;
      rpt_armed_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge cr)
    if (!cr) begin
      state    <= SCAN;
      row_idx  <= '0;
      cap_c    <= '0;
      cnt      <= '0;
      key_code <= '0;
      key_held <= 1'b0;
      kv_q     <= 1'b0;
    end else begin
      state    <= state_n;
      row_idx  <= row_idx_n;
      cap_c    <= cap_c_n;
      cnt      <= cnt_n;
      key_code <= code_n;
      key_held <= held_n;
      kv_q     <= kv_n;
    end

  assign row       = row_drive(row_idx);
  assign key_valid = kv_q & en;

endmodule
